// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and the
// fixed divide results for divide-by-zero and signed overflow.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_NOR   = 4'h5;
   localparam logic [3:0] OP_SLL   = 4'h6;
   localparam logic [3:0] OP_SRL   = 4'h7;
   localparam logic [3:0] OP_SRA   = 4'h8;
   localparam logic [3:0] OP_SLT   = 4'h9;
   localparam logic [3:0] OP_MULT  = 4'hA;
   localparam logic [3:0] OP_DIV   = 4'hB;
   localparam logic [3:0] OP_MULTU = 4'hC;
   localparam logic [3:0] OP_DIVU  = 4'hD;

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

   // Returns {hi, lo} in 64-bit lanes; callers slice the low w bits of each.
   // divz: LO = all ones, HI = dividend.  Otherwise overflow: LO = MIN, HI = 0.
   function automatic logic [127:0] div_rule(input logic [63:0] a, input logic divz,
                                             input int w);
      logic [63:0] ones;
      logic [63:0] min;
      ones = (64'(1) << w) - 64'(1);
      min  = 64'(1) << (w - 1);
      return divz ? {a, ones} : {64'(0), min};
   endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// One-bit-per-cycle unsigned engine: shift-add multiply or restoring divide
// on operand magnitudes, with its own iteration counter.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a_mag,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             last
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     sum, rsh, trial;

   // acc holds {partial product, multiplier} or {remainder, quotient/dividend}
   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      rsh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial = rsh - {1'b0, opnd};
      if (!is_div)
         acc_nxt = {sum, acc[WIDTH-1:1]};
      else if (trial[WIDTH])
         acc_nxt = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc  <= '0;
         opnd <= '0;
         cnt  <= '0;
      end else if (load) begin
         acc  <= {{WIDTH{1'b0}}, a_mag};
         opnd <= b_mag;
         cnt  <= CW'(WIDTH - 1);
      end else if (step) begin
         acc  <= acc_nxt;
         cnt  <= cnt - 1'b1;
      end
   end

   assign hi   = acc[2*WIDTH-1:WIDTH];
   assign lo   = acc[WIDTH-1:0];
   assign last = (cnt == '0);
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: combinational single-cycle ops plus an iterative mul/div
// unit that stalls the pipeline and deposits its result in HI/LO.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             stall
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state, nstate;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic             issue, signed_in, signed_r, is_div, a_neg, b_neg, last;
   logic [WIDTH-1:0] a_mag, b_mag, raw_hi, raw_lo, fix_hi, fix_lo, diff;
   logic [2*WIDTH-1:0] prod;
   logic [127:0]     rule;

   always_comb begin
      diff = A - B;
      case (op)
         OP_ADD:  out = A + B;
         OP_SUB:  out = diff;
         OP_AND:  out = A & B;
         OP_OR:   out = A | B;
         OP_XOR:  out = A ^ B;
         OP_NOR:  out = ~(A | B);
         OP_SLL:  out = B << A[SW-1:0];
         OP_SRL:  out = B >> A[SW-1:0];
         OP_SRA:  out = $signed(B) >>> A[SW-1:0];
         OP_SLT:  out = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
         default: out = '0;
      endcase
   end

   assign issue     = (state == ST_IDLE) && valid && is_muldiv(op);
   assign stall     = rst_n && (issue || (state == ST_CALC));
   assign signed_in = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag     = (signed_in && A[WIDTH-1]) ? -A : A;
   assign b_mag     = (signed_in && B[WIDTH-1]) ? -B : B;
   assign signed_r  = (op_r == OP_MULT) || (op_r == OP_DIV);
   assign is_div    = (op_r == OP_DIV) || (op_r == OP_DIVU);
   assign a_neg     = signed_r && a_r[WIDTH-1];
   assign b_neg     = signed_r && b_r[WIDTH-1];

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (issue),
      .step   (state == ST_CALC),
      .is_div (is_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .hi     (raw_hi),
      .lo     (raw_lo),
      .last   (last)
   );

   // Sign correction; the remainder follows the dividend's sign
   always_comb begin
      prod = {raw_hi, raw_lo};
      if (a_neg ^ b_neg) prod = -prod;
      rule = div_rule(64'(a_r), b_r == '0, WIDTH);
      if (!is_div) begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end else if ((b_r == '0) || (signed_r && a_r == MIN && b_r == '1)) begin
         fix_hi = rule[64 +: WIDTH];
         fix_lo = rule[0 +: WIDTH];
      end else begin
         fix_hi = a_neg ? -raw_hi : raw_hi;
         fix_lo = (a_neg ^ b_neg) ? -raw_lo : raw_lo;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE: if (issue) nstate = ST_CALC;
         ST_CALC: if (last)  nstate = ST_FIX;
         ST_FIX:             nstate = ST_IDLE;
         default:            nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         op_r  <= '0;
         a_r   <= '0;
         b_r   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= nstate;
         if (issue) begin
            op_r <= op;
            a_r  <= A;
            b_r  <= B;
         end
         if (state == ST_FIX) begin
            HI <= fix_hi;
            LO <= fix_lo;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table for single-cycle ops, scoreboarded mul/div
// runs at WIDTH=32, plus hand sequences for overlap, reset abort and WIDTH=8.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n, valid, valid8;
   logic [3:0]  op, op8;
   logic [31:0] A, B, out, HI, LO;
   logic [7:0]  a8, b8, out8, hi8, lo8;
   logic        stall, stall8;

   int passes = 0;
   int total  = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .A(A), .B(B),
      .out(out), .HI(HI), .LO(LO), .stall(stall)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .valid(valid8), .op(op8), .A(a8), .B(b8),
      .out(out8), .HI(hi8), .LO(lo8), .stall(stall8)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({e.name, " HI"}, 64'(HI), 64'(e.hi));
         chk({e.name, " LO"}, 64'(LO), 64'(e.lo));
      end
   endtask

   // Issue one mul/div, count stall cycles, then compare HI/LO after FIX
   task automatic run_md(input string nm, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int n;
      sb.push_back('{nm, eh, el});
      @(negedge clk);
      valid = 1'b1; op = o; A = a; B = b;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!stall) break;
         n++;
         @(negedge clk);
         valid = 1'b0;
      end
      valid = 1'b0;
      chk({nm, " stall cycles"}, 64'(n), 64'd33);
      @(posedge clk);
      @(negedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      int n;
      rst_n = 1'b0; valid = 1'b0; valid8 = 1'b0;
      op = 4'h0; A = '0; B = '0; op8 = 4'h0; a8 = '0; b8 = '0;

      vecs.push_back('{"add",       4'h0, 32'h5,        32'h7,        32'hC});
      vecs.push_back('{"add wrap",  4'h0, 32'hFFFFFFFF, 32'h1,        32'h0});
      vecs.push_back('{"sub",       4'h1, 32'h3,        32'h5,        32'hFFFFFFFE});
      vecs.push_back('{"and",       4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
      vecs.push_back('{"or",        4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0});
      vecs.push_back('{"xor",       4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0});
      vecs.push_back('{"nor",       4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F});
      vecs.push_back('{"sll",       4'h6, 32'h4,        32'h1,        32'h10});
      vecs.push_back('{"sll mask",  4'h6, 32'h24,       32'h1,        32'h10});
      vecs.push_back('{"srl",       4'h7, 32'h4,        32'h80000000, 32'h08000000});
      vecs.push_back('{"sra",       4'h8, 32'h4,        32'h80000000, 32'hF8000000});
      vecs.push_back('{"slt neg",   4'h9, 32'hFFFFFFFF, 32'h1,        32'h1});
      vecs.push_back('{"slt lt",    4'h9, 32'h1,        32'h2,        32'h1});
      vecs.push_back('{"slt ge",    4'h9, 32'h5,        32'h2,        32'h0});
      vecs.push_back('{"slt ovf",   4'h9, 32'h80000000, 32'h1,        32'h0});
      vecs.push_back('{"op mult",   4'hA, 32'h5,        32'h5,        32'h0});
      vecs.push_back('{"op E",      4'hE, 32'h5,        32'h5,        32'h0});
      vecs.push_back('{"op F",      4'hF, 32'h5,        32'h5,        32'h0});

      repeat (2) @(negedge clk);
      #1;
      chk("reset stall", 64'(stall), 64'd0);
      chk("reset HI",    64'(HI),    64'd0);
      chk("reset LO",    64'(LO),    64'd0);
      chk("reset stall8", 64'(stall8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
         #1;
         chk(vecs[i].name, 64'(out), 64'(vecs[i].exp));
      end

      run_md("mult -3*7",   4'hA, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      run_md("div -7/2",    4'hB, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run_md("divu",        4'hD, 32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC);
      run_md("divu by 0",   4'hD, 32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF);
      run_md("div ovf",     4'hB, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_md("div by 0",    4'hB, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF);
      run_md("div 100/-7",  4'hB, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
      run_md("multu max",   4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_md("mult min*2",  4'hA, 32'h80000000, 32'h2,        32'hFFFFFFFF, 32'h00000000);

      // Single-cycle op and a second mul/div request while the first runs
      sb.push_back('{"overlap mult", 32'h0, 32'd25});
      @(negedge clk);
      valid = 1'b1; op = 4'hA; A = 32'd5; B = 32'd5;
      #1;
      chk("overlap issue stall", 64'(stall), 64'd1);
      @(negedge clk);
      op = 4'h0; A = 32'd3; B = 32'd4;
      #1;
      chk("overlap add out",   64'(out),   64'd7);
      chk("overlap add stall", 64'(stall), 64'd1);
      op = 4'hC; A = 32'd9; B = 32'd9;
      n = 2;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (!stall) break;
         n++;
      end
      chk("overlap stall cycles", 64'(n), 64'd33);
      @(negedge clk);
      valid = 1'b0;
      #1;
      pop_check();
      chk("overlap idle stall", 64'(stall), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("overlap LO held", 64'(LO), 64'd25);

      // Reset on the 10th CALC cycle aborts the divide
      @(negedge clk);
      valid = 1'b1; op = 4'hB; A = 32'hFFFFFFF9; B = 32'h2;
      repeat (10) @(negedge clk);
      valid = 1'b0;
      #1;
      chk("abort calc stall", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort stall in reset", 64'(stall), 64'd0);
      @(negedge clk);
      #1;
      chk("abort stall", 64'(stall), 64'd0);
      chk("abort HI",    64'(HI),    64'd0);
      chk("abort LO",    64'(LO),    64'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("abort HI later", 64'(HI), 64'd0);
      chk("abort LO later", 64'(LO), 64'd0);
      run_md("post abort divu", 4'hD, 32'd100, 32'd7, 32'd2, 32'd14);

      // WIDTH=8 instance
      @(negedge clk);
      valid8 = 1'b1; op8 = 4'hC; a8 = 8'hFF; b8 = 8'hFF;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (!stall8) break;
         n++;
         @(negedge clk);
         valid8 = 1'b0;
      end
      valid8 = 1'b0;
      chk("w8 stall cycles", 64'(n), 64'd9);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("w8 HI", 64'(hi8), 64'hFE);
      chk("w8 LO", 64'(lo8), 64'h01);
      op8 = 4'h8; a8 = 8'h0B; b8 = 8'h80;
      #1;
      chk("w8 sra mask", 64'(out8), 64'hF0);

      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
